top_uart_rx: RTL and testbench



---
 rtl/top_uart_rx.sv | 130 +++++++++++++
 tb/tb_top_uart_rx.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/top_uart_rx.sv
// 8N1 UART receiver: two-FF synchronizer, oversampling tick, 3-sample mid-bit majority vote.
// Each frame ends in exactly one single-cycle rx_valid or rx_frame_err pulse.
module top_uart_rx #(
   parameter int CLK_FREQUENCY = 100_000_000,
   parameter int BAUD_RATE     = 115200,
   parameter int OVERSAMPLING  = 16
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       rx,
   output logic [7:0] rx_data,
   output logic       rx_valid,
   output logic       rx_frame_err,
   output logic       rx_busy
);

   localparam int TICK_BASE = BAUD_RATE * OVERSAMPLING;
   localparam int TICK_RAW  = (CLK_FREQUENCY + TICK_BASE / 2) / TICK_BASE;
   localparam int TICK_DIV  = (TICK_RAW < 1) ? 1 : TICK_RAW;
   localparam int TW        = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
   localparam int SW        = $clog2(OVERSAMPLING);
   localparam int M         = OVERSAMPLING / 2;

   localparam logic [TW-1:0] TICK_LAST = TW'(TICK_DIV - 1);
   localparam logic [SW-1:0] S_LAST    = SW'(OVERSAMPLING - 1);
   localparam logic [SW-1:0] S_LO      = SW'(M - 1);
   localparam logic [SW-1:0] S_MID     = SW'(M);
   localparam logic [SW-1:0] S_HI      = SW'(M + 1);

   typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

   state_t          state_q;
   logic            sync1_q;
   logic            rx_s_q;
   logic            rx_p_q;
   logic [TW-1:0]   tick_cnt_q;
   logic [SW-1:0]   s_cnt_q;
   logic [2:0]      samp_q;
   logic [2:0]      samp_d;
   logic [2:0]      bit_idx_q;
   logic [7:0]      shift_q;
   logic [7:0]      data_q;
   logic            valid_q;
   logic            ferr_q;
   logic            tick;
   logic            in_window;
   logic            maj;

   assign tick      = (tick_cnt_q == TICK_LAST);
   assign in_window = (s_cnt_q == S_LO) || (s_cnt_q == S_MID) || (s_cnt_q == S_HI);

   // The vote at s_cnt==M+1 must include the sample being captured in that same cycle.
   assign samp_d = (tick && in_window) ? {samp_q[1:0], rx_s_q} : samp_q;
   assign maj    = (samp_d[0] & samp_d[1]) | (samp_d[0] & samp_d[2]) | (samp_d[1] & samp_d[2]);

   always_ff @(posedge clk) begin
      if (reset) begin
         state_q    <= IDLE;
         sync1_q    <= 1'b1;
         rx_s_q     <= 1'b1;
         rx_p_q     <= 1'b1;
         tick_cnt_q <= '0;
         s_cnt_q    <= '0;
         samp_q     <= '0;
         bit_idx_q  <= '0;
         shift_q    <= '0;
         data_q     <= '0;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
      end else begin
         sync1_q    <= rx;
         rx_s_q     <= sync1_q;
         rx_p_q     <= rx_s_q;
         valid_q    <= 1'b0;
         ferr_q     <= 1'b0;
         tick_cnt_q <= tick ? '0 : tick_cnt_q + 1'b1;
         if (tick) begin
            samp_q  <= samp_d;
            s_cnt_q <= (s_cnt_q == S_LAST) ? '0 : s_cnt_q + 1'b1;
         end

         case (state_q)
            IDLE: begin
               if (rx_p_q && !rx_s_q) begin
                  state_q    <= START;
                  tick_cnt_q <= '0;
                  s_cnt_q    <= '0;
                  bit_idx_q  <= '0;
               end
            end
            START: begin
               if (tick) begin
                  if (s_cnt_q == S_HI && maj) begin
                     state_q <= IDLE;
                  end else if (s_cnt_q == S_LAST) begin
                     state_q <= DATA;
                     s_cnt_q <= '0;
                  end
               end
            end
            DATA: begin
               if (tick && s_cnt_q == S_LAST) begin
                  shift_q   <= {maj, shift_q[7:1]};
                  s_cnt_q   <= '0;
                  bit_idx_q <= bit_idx_q + 1'b1;
                  if (bit_idx_q == 3'd7) begin
                     state_q <= STOP;
                  end
               end
            end
            STOP: begin
               // Decide at mid-stop and leave at once so back-to-back frames keep half a bit of margin.
               if (tick && s_cnt_q == S_HI) begin
                  data_q  <= shift_q;
                  valid_q <= maj;
                  ferr_q  <= ~maj;
                  state_q <= IDLE;
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   assign rx_data      = data_q;
   assign rx_valid     = valid_q;
   assign rx_frame_err = ferr_q;
   assign rx_busy      = (state_q != IDLE);

endmodule

// File: tb/tb_top_uart_rx.sv
// Directed bench for top_uart_rx at 16 clocks per bit (TICK_DIV=1).
// A negedge monitor counts pulses; the main sequence asserts on counts, data and latency.
module tb_top_uart_rx;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       rx = 1'b1;
   logic [7:0] rx_data;
   logic       rx_valid;
   logic       rx_frame_err;
   logic       rx_busy;

   int vectors = 0;
   int miscompares = 0;
   int cyc = 0;
   int start_cyc = 0;
   int valid_cnt = 0;
   int err_cnt = 0;
   int both_cnt = 0;
   int valid_cyc = 0;
   int err_cyc = 0;
   logic [7:0] got_q[$];

   top_uart_rx #(
      .CLK_FREQUENCY(1_600_000),
      .BAUD_RATE    (100_000),
      .OVERSAMPLING (16)
   ) dut (
      .clk         (clk),
      .reset       (reset),
      .rx          (rx),
      .rx_data     (rx_data),
      .rx_valid    (rx_valid),
      .rx_frame_err(rx_frame_err),
      .rx_busy     (rx_busy)
   );

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   always @(negedge clk) begin
      if (rx_valid) begin
         valid_cnt <= valid_cnt + 1;
         valid_cyc <= cyc;
         got_q.push_back(rx_data);
      end
      if (rx_frame_err) begin
         err_cnt <= err_cnt + 1;
         err_cyc <= cyc;
      end
      if (rx_valid && rx_frame_err) both_cnt <= both_cnt + 1;
   end

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic bit_time(input logic b);
      rx = b;
      repeat (16) @(negedge clk);
   endtask

   // Full 8N1 frame; start_cyc marks the cycle in which the start bit is driven.
   task automatic send(input logic [7:0] b, input logic stop_bit);
      start_cyc = cyc;
      bit_time(1'b0);
      for (int i = 0; i < 8; i++) bit_time(b[i]);
      bit_time(stop_bit);
   endtask

   initial begin
      repeat (3) @(negedge clk);
      check("reset_data", rx_data, 8'h00);
      check("reset_valid", rx_valid, 1'b0);
      check("reset_ferr", rx_frame_err, 1'b0);
      check("reset_busy", rx_busy, 1'b0);
      reset = 1'b0;
      repeat (5) @(negedge clk);

      // 0xA5: pulse expected 2 sync cycles + 155 after the start bit is driven
      send(8'hA5, 1'b1);
      repeat (20) @(negedge clk);
      check("a5_data", rx_data, 8'hA5);
      check("a5_valid_cnt", valid_cnt, 1);
      check("a5_ferr_cnt", err_cnt, 0);
      check("a5_latency", valid_cyc - start_cyc, 157);
      check("a5_busy_after", rx_busy, 1'b0);

      // back-to-back 0x00 then 0xFF with a 16-cycle stop bit
      send(8'h00, 1'b1);
      send(8'hFF, 1'b1);
      repeat (20) @(negedge clk);
      check("b2b_valid_cnt", valid_cnt, 3);
      check("b2b_first", got_q[1], 8'h00);
      check("b2b_second", got_q[2], 8'hFF);
      check("b2b_ferr_cnt", err_cnt, 0);

      // bad stop bit
      send(8'h3C, 1'b0);
      rx = 1'b1;
      repeat (20) @(negedge clk);
      check("ferr_data", rx_data, 8'h3C);
      check("ferr_cnt", err_cnt, 1);
      check("ferr_valid_cnt", valid_cnt, 3);
      check("ferr_latency", err_cyc - start_cyc, 157);

      // 4-cycle glitch: START is entered, then rejected by the vote
      rx = 1'b0;
      repeat (4) @(negedge clk);
      rx = 1'b1;
      repeat (2) @(negedge clk);
      check("glitch_busy_start", rx_busy, 1'b1);
      repeat (20) @(negedge clk);
      check("glitch_busy_idle", rx_busy, 1'b0);
      check("glitch_valid_cnt", valid_cnt, 3);
      check("glitch_ferr_cnt", err_cnt, 1);
      check("glitch_data", rx_data, 8'h3C);

      // 0x55 aborted by reset in bit 4, then 0x81
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      bit_time(1'b1);
      bit_time(1'b0);
      rx = 1'b1;
      repeat (8) @(negedge clk);
      check("abort_busy_mid", rx_busy, 1'b1);
      reset = 1'b1;
      @(negedge clk);
      reset = 1'b0;
      repeat (200) @(negedge clk);
      check("abort_valid_cnt", valid_cnt, 3);
      check("abort_ferr_cnt", err_cnt, 1);
      check("abort_data_reset", rx_data, 8'h00);
      check("abort_busy", rx_busy, 1'b0);
      send(8'h81, 1'b1);
      repeat (20) @(negedge clk);
      check("post_reset_valid_cnt", valid_cnt, 4);
      check("post_reset_data", rx_data, 8'h81);
      check("post_reset_latency", valid_cyc - start_cyc, 157);

      // one good frame, then break for 40 bit times
      send(8'h5A, 1'b1);
      repeat (4) @(negedge clk);
      check("pre_break_data", rx_data, 8'h5A);
      start_cyc = cyc;
      rx = 1'b0;
      repeat (640) @(negedge clk);
      check("break_ferr_cnt", err_cnt, 2);
      check("break_data", rx_data, 8'h00);
      check("break_valid_cnt", valid_cnt, 5);
      check("break_busy", rx_busy, 1'b0);
      check("break_latency", err_cyc - start_cyc, 157);
      rx = 1'b1;
      repeat (40) @(negedge clk);
      check("break_release_ferr_cnt", err_cnt, 2);
      send(8'hC3, 1'b1);
      repeat (20) @(negedge clk);
      check("after_break_valid_cnt", valid_cnt, 6);
      check("after_break_data", rx_data, 8'hC3);
      check("after_break_ferr_cnt", err_cnt, 2);
      check("never_both", both_cnt, 0);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
